fir_seq_ctrl: RTL and testbench
===============================

# fir_seq_ctrl

Sequencing controller for the 11-tap FIR engine. Owns the ap_start/ap_done/ap_idle protocol, accepts stream samples, writes them into the circular data BRAM, and walks the tap and data BRAMs once per sample while driving the external MAC datapath. Results are then handed to the output stream. It sits between the AXI-lite config registers, the two bram11 instances and the multiply-accumulate datapath.

## Interface
Parameters:
- pADDR_WIDTH, 12, BRAM byte-address width
- TAP_MAX, 11, BRAM depth in words; maximum tap count

Ports:
- axis_clk  in  1  sole clock
- axis_rst  in  1  asynchronous, active-high reset
- ap_start  in  1  one-cycle start pulse from config register 0x00 bit 0
- ap_done_clr  in  1  pulse when register 0x00 is read; clears ap_done
- cfg_data_length  in  32  samples per run (register 0x10)
- cfg_tap_num  in  4  taps in use (register 0x14)
- ap_idle  out  1  engine idle
- ap_done  out  1  sticky run-complete flag
- cfg_lock  out  1  tap RAM owned by engine; AXI-lite tap accesses must stall
- ss_tvalid  in  1, ss_tlast  in  1, ss_tready  out  1: input stream handshake
- sm_tvalid  out  1, sm_tready  in  1, sm_tlast  out  1: output stream handshake
- tap_EN  out  1, tap_A  out  pADDR_WIDTH: tap BRAM read port (read-only here)
- data_EN  out  1, data_WE  out  4, data_A  out  pADDR_WIDTH: data BRAM port
- data_zero  out  1  datapath drives data_Di=0 instead of ss_tdata
- mac_en  out  1  accumulate tap_Do*data_Do this cycle
- mac_first  out  1  with mac_en: load the product, do not add to the accumulator

## Operation
- States: IDLE, CLEAR, WAIT_IN, MAC, OUT.
- Addresses are byte addresses: word index times 4.
- IDLE: ap_idle=1, cfg_lock=0. A start is accepted when ap_start=1, 1<=cfg_tap_num<=TAP_MAX and cfg_data_length!=0.
  - On an accepted start: ap_done clears, wptr=0, sample count=0, go to CLEAR (or to WAIT_IN, see Configuration).
  - If any start condition fails, ap_start is ignored.
- CLEAR: TAP_MAX cycles with data_EN=1, data_WE=4'hF, data_zero=1, data_A=4*i for i=0..TAP_MAX-1, then go to WAIT_IN.
- WAIT_IN: ss_tready=1, data_EN=1, data_WE=ss_tvalid?4'hF:0, data_A=4*wptr.
  - On handshake the sample is written, ss_tlast is latched, k=0, go to MAC.
- MAC: runs cfg_tap_num+1 cycles.
  - Issue cycle k (k<N): tap_A=4*k, data_A=4*((wptr-k) mod TAP_MAX), both EN=1.
  - mac_en=1 in the cycle after each issue (BRAM read latency 1).
  - mac_first=1 on the k=0 data cycle.
- OUT: sm_tvalid=1 and held until sm_tready.
  - sm_tlast=1 when the latched tlast=1 or count==cfg_data_length-1.
  - On handshake: wptr=(wptr+1) mod TAP_MAX and count++.
  - If last: ap_done=1 and go to IDLE; otherwise go to WAIT_IN.
- ap_done stays set until ap_done_clr or the next accepted start. When both occur in the same cycle as the set, the set wins.
- cfg_lock=1 in every state except IDLE.
- ap_start outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, ap_idle=1, every other output 0, wptr=0, count=0.
- Reset mid-run aborts immediately. No ap_done is produced.
- Per-sample cost with sm_tready=1: 1 (WAIT_IN) + N+1 (MAC) + 1 (OUT) = N+3 cycles. For N=11 this is 14 cycles.
- First sm_tvalid rises N+2 cycles after the first ss handshake edge.
- Pointer wraps 10->0. Read index (wptr-k) wraps modulo TAP_MAX, with no negative intermediate values.
- ss_tvalid is never sampled outside WAIT_IN. sm_tvalid never drops without a handshake.
- Early ss_tlast (before count reaches length-1) ends the run at that sample.

## Configuration
- FIR_CTRL_ZERO_FILL_EN defined: the CLEAR state exists, and every issue cycle asserts mac_en.
- FIR_CTRL_ZERO_FILL_EN undefined:
  - The CLEAR state is removed; start goes directly to WAIT_IN.
  - A saturating counter of samples received (max TAP_MAX) suppresses mac_en for taps k >= samples received.
  - The suppressed reads still occur, keeping timing identical apart from the absent CLEAR cycles.
- Both builds must produce identical sm outputs from the datapath.

## Structure
- Shared package fir_pkg: state enum, TAP_MAX, ADDR_STRIDE=4, register offsets 0x00/0x10/0x14/0x40.
- Sub-module fir_addr_gen: holds wptr, the k counter and the modulo-TAP_MAX read-index computation. The FSM stays in fir_seq_ctrl.

## Test plan
- Reset, then ap_start with cfg_tap_num=11, length=600 -> ap_idle falls the next cycle; CLEAR writes addresses 0x00..0x28 with data_zero=1.
- First sample, sm_tready=1 -> mac_en high 11 cycles, mac_first on the first; sm_tvalid N+2 cycles after the ss edge; 14-cycle sample period.
- 12th sample -> written at data_A=0x00 (wrap); k=1 reads 0x28.
- Hold sm_tready=0 for 5 cycles in OUT -> sm_tvalid held, ss_tready=0, wptr unchanged.
- ss_tlast on sample 9 with length=600 -> sm_tlast on output 9, ap_done=1, ap_idle=1; ap_done_clr -> ap_done=0.
- ap_start with cfg_tap_num=0, and ap_start mid-run -> both ignored; axis_rst mid-MAC -> all outputs 0, ap_idle=1.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared definitions for the FIR sequencing controller.
//   - fir_state_e : controller state encoding (exported on dbg_state)
//   - TAP_MAX     : BRAM depth in words, also the maximum tap count
//   - ADDR_STRIDE : bytes per BRAM word (BRAM ports take byte addresses)
//   - REG_*       : AXI-lite register offsets used by the config block
package fir_pkg;

    localparam int TAP_MAX     = 11;
    localparam int ADDR_STRIDE = 4;

    localparam logic [11:0] REG_AP_CTRL  = 12'h000;
    localparam logic [11:0] REG_DATA_LEN = 12'h010;
    localparam logic [11:0] REG_TAP_NUM  = 12'h014;
    localparam logic [11:0] REG_TAP_BASE = 12'h040;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_MAC     = 3'd3,
        ST_OUT     = 3'd4
    } fir_state_e;

endpackage

// File: rtl/fir_addr_gen.sv
// fir_addr_gen: pointer and address generation for the FIR controller.
// Holds the circular write pointer (wptr) and the tap/clear index k, and
// turns them into BRAM byte addresses.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wptr_clr, wptr_adv  reset / advance (mod TAP_MAX) the write pointer
//   k_clr, k_inc        reset / increment the tap index
//   k                   current tap index
//   wr_addr             4*wptr       (sample write address)
//   rd_addr             4*((wptr-k) mod TAP_MAX) (delay-line read address)
//   k_addr              4*k          (tap read / clear address)
module fir_addr_gen #(
    parameter int pADDR_WIDTH = 12,
    parameter int TAP_MAX     = 11,
    parameter int IW          = $clog2(TAP_MAX + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wptr_clr,
    input  logic                   wptr_adv,
    input  logic                   k_clr,
    input  logic                   k_inc,
    output logic [IW-1:0]          k,
    output logic [pADDR_WIDTH-1:0] wr_addr,
    output logic [pADDR_WIDTH-1:0] rd_addr,
    output logic [pADDR_WIDTH-1:0] k_addr
);
    import fir_pkg::*;

    logic [IW-1:0] wptr_q, wptr_d;
    logic [IW-1:0] k_q, k_d;
    logic [IW-1:0] rd_idx;
    logic [IW:0]   wrap_sum;

    always_comb begin
        wptr_d = wptr_q;
        if (wptr_clr)
            wptr_d = '0;
        else if (wptr_adv)
            wptr_d = (wptr_q == IW'(TAP_MAX - 1)) ? '0 : wptr_q + IW'(1);

        k_d = k_q;
        if (k_clr)
            k_d = '0;
        else if (k_inc)
            k_d = k_q + IW'(1);

        // Add TAP_MAX before subtracting when k > wptr so the index never
        // goes negative; one extra bit holds wptr + TAP_MAX.
        wrap_sum = {1'b0, wptr_q} + (IW + 1)'(TAP_MAX);
        if (wptr_q >= k_q)
            rd_idx = wptr_q - k_q;
        else
            rd_idx = IW'(wrap_sum - {1'b0, k_q});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            k_q    <= '0;
        end else begin
            wptr_q <= wptr_d;
            k_q    <= k_d;
        end
    end

    assign k       = k_q;
    assign wr_addr = pADDR_WIDTH'(wptr_q) * pADDR_WIDTH'(ADDR_STRIDE);
    assign rd_addr = pADDR_WIDTH'(rd_idx) * pADDR_WIDTH'(ADDR_STRIDE);
    assign k_addr  = pADDR_WIDTH'(k_q)    * pADDR_WIDTH'(ADDR_STRIDE);

endmodule

// File: rtl/fir_seq_ctrl.sv
// fir_seq_ctrl: sequencing controller for the 11-tap FIR engine.
// Runs ap_start/ap_done/ap_idle, takes one stream sample at a time, writes
// it into the circular data BRAM, walks tap and data BRAMs to drive the
// external MAC, then presents the result on the output stream.
//
// Build option: FIR_CTRL_ZERO_FILL_EN
//   defined   - a CLEAR pass zeroes the data BRAM after start; every tap
//               read is accumulated.
//   undefined - no CLEAR pass; a saturating received-sample counter masks
//               mac_en for taps older than the first sample of the run.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both 1. ss_tready is only ever 1 in WAIT_IN. sm_tvalid, once
// raised, stays 1 (with stable sm_tlast) until the sm_tready transfer.
//
// Ports:
//   axis_clk, axis_rst     clock, asynchronous active-high reset
//   ap_start, ap_done_clr  start pulse, clear of the sticky done flag
//   cfg_data_length        samples per run
//   cfg_tap_num            taps in use (1..TAP_MAX)
//   ap_idle, ap_done       status; cfg_lock = tap RAM owned by the engine
//   ss_*, sm_*             input / output stream handshake
//   tap_EN, tap_A          tap BRAM read port
//   data_EN/WE/A, data_zero data BRAM port; data_zero selects 0 as write data
//   mac_en, mac_first      accumulate / load product in the MAC datapath
//   dbg_state              current controller state (fir_state_e)
module fir_seq_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int TAP_MAX     = fir_pkg::TAP_MAX
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst,
    input  logic                   ap_start,
    input  logic                   ap_done_clr,
    input  logic [31:0]            cfg_data_length,
    input  logic [3:0]             cfg_tap_num,
    output logic                   ap_idle,
    output logic                   ap_done,
    output logic                   cfg_lock,
    input  logic                   ss_tvalid,
    input  logic                   ss_tlast,
    output logic                   ss_tready,
    output logic                   sm_tvalid,
    input  logic                   sm_tready,
    output logic                   sm_tlast,
    output logic                   tap_EN,
    output logic [pADDR_WIDTH-1:0] tap_A,
    output logic                   data_EN,
    output logic [3:0]             data_WE,
    output logic [pADDR_WIDTH-1:0] data_A,
    output logic                   data_zero,
    output logic                   mac_en,
    output logic                   mac_first,
    output logic [2:0]             dbg_state
);
    import fir_pkg::*;

    localparam int IW = $clog2(TAP_MAX + 1);

    fir_state_e    state_q, state_d;
    logic          done_q, done_d;
    logic          tlast_q, tlast_d;
    logic [31:0]   cnt_q, cnt_d;
    logic          wptr_clr, wptr_adv, k_clr, k_inc;
    logic [IW-1:0] k;
    logic [IW-1:0] tap_n;
    logic          start_ok;
    logic          out_last;
    logic [pADDR_WIDTH-1:0] wr_addr, rd_addr, k_addr;
`ifndef FIR_CTRL_ZERO_FILL_EN
    logic [IW-1:0] rcv_q, rcv_d;
`endif

    fir_addr_gen #(
        .pADDR_WIDTH (pADDR_WIDTH),
        .TAP_MAX     (TAP_MAX),
        .IW          (IW)
    ) u_addr_gen (
        .clk      (axis_clk),
        .rst      (axis_rst),
        .wptr_clr (wptr_clr),
        .wptr_adv (wptr_adv),
        .k_clr    (k_clr),
        .k_inc    (k_inc),
        .k        (k),
        .wr_addr  (wr_addr),
        .rd_addr  (rd_addr),
        .k_addr   (k_addr)
    );

    assign tap_n    = IW'(cfg_tap_num);
    assign start_ok = ap_start && (cfg_tap_num != 4'd0) &&
                      (int'(cfg_tap_num) <= TAP_MAX) && (cfg_data_length != 32'd0);
    assign out_last = tlast_q || (cnt_q == cfg_data_length - 32'd1);

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        tlast_d   = tlast_q;
        cnt_d     = cnt_q;
`ifndef FIR_CTRL_ZERO_FILL_EN
        rcv_d     = rcv_q;
`endif
        wptr_clr  = 1'b0;
        wptr_adv  = 1'b0;
        k_clr     = 1'b0;
        k_inc     = 1'b0;
        ap_idle   = 1'b0;
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        tap_EN    = 1'b0;
        tap_A     = '0;
        data_EN   = 1'b0;
        data_WE   = 4'h0;
        data_A    = '0;
        data_zero = 1'b0;
        mac_en    = 1'b0;
        mac_first = 1'b0;

        // The set in OUT below overrides this clear in the same cycle.
        if (ap_done_clr)
            done_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                ap_idle = 1'b1;
                if (start_ok) begin
                    done_d   = 1'b0;
                    cnt_d    = '0;
                    wptr_clr = 1'b1;
                    k_clr    = 1'b1;
`ifdef FIR_CTRL_ZERO_FILL_EN
                    state_d  = ST_CLEAR;
`else
                    rcv_d    = '0;
                    state_d  = ST_WAIT_IN;
`endif
                end
            end
            ST_CLEAR: begin
                data_EN   = 1'b1;
                data_WE   = 4'hF;
                data_zero = 1'b1;
                data_A    = k_addr;
                k_inc     = 1'b1;
                if (k == IW'(TAP_MAX - 1))
                    state_d = ST_WAIT_IN;
            end
            ST_WAIT_IN: begin
                ss_tready = 1'b1;
                data_EN   = 1'b1;
                data_WE   = ss_tvalid ? 4'hF : 4'h0;
                data_A    = wr_addr;
                if (ss_tvalid) begin
                    tlast_d = ss_tlast;
                    k_clr   = 1'b1;
`ifndef FIR_CTRL_ZERO_FILL_EN
                    if (rcv_q != IW'(TAP_MAX))
                        rcv_d = rcv_q + IW'(1);
`endif
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                // Cycle k issues reads for tap k; the BRAM data for tap k-1
                // arrives in the same cycle, so accumulate on k >= 1.
                k_inc = 1'b1;
                if (k < tap_n) begin
                    tap_EN  = 1'b1;
                    tap_A   = k_addr;
                    data_EN = 1'b1;
                    data_A  = rd_addr;
                end
                if (k != '0) begin
`ifdef FIR_CTRL_ZERO_FILL_EN
                    mac_en = 1'b1;
`else
                    // Tap k-1 reads a real sample only if k-1 < samples received.
                    mac_en = (k <= rcv_q);
`endif
                    mac_first = (k == IW'(1));
                end
                if (k == tap_n)
                    state_d = ST_OUT;
            end
            ST_OUT: begin
                sm_tvalid = 1'b1;
                sm_tlast  = out_last;
                if (sm_tready) begin
                    wptr_adv = 1'b1;
                    cnt_d    = cnt_q + 32'd1;
                    if (out_last) begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT_IN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk or posedge axis_rst) begin
        if (axis_rst) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            tlast_q <= 1'b0;
            cnt_q   <= '0;
`ifndef FIR_CTRL_ZERO_FILL_EN
            rcv_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            tlast_q <= tlast_d;
            cnt_q   <= cnt_d;
`ifndef FIR_CTRL_ZERO_FILL_EN
            rcv_q   <= rcv_d;
`endif
        end
    end

    assign ap_done   = done_q;
    assign cfg_lock  = (state_q != ST_IDLE);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
module tb_fir_seq_ctrl;

  localparam int NT = 11;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        ap_start = 1'b0, ap_done_clr = 1'b0;
  logic [31:0] cfg_data_length = 32'd0;
  logic [3:0]  cfg_tap_num = 4'd0;
  logic        ap_idle, ap_done, cfg_lock;
  logic        ss_tvalid = 1'b0, ss_tlast = 1'b0, ss_tready;
  logic        sm_tvalid, sm_tready, sm_tlast;
  logic        tap_EN, data_EN, data_zero, mac_en, mac_first;
  logic [11:0] tap_A, data_A;
  logic [3:0]  data_WE;
  logic [2:0]  dbg_state;
  logic [31:0] ss_tdata = 32'd0;

  fir_seq_ctrl #(.pADDR_WIDTH(12), .TAP_MAX(NT)) dut (
    .axis_clk(clk), .axis_rst(rst), .ap_start(ap_start), .ap_done_clr(ap_done_clr),
    .cfg_data_length(cfg_data_length), .cfg_tap_num(cfg_tap_num),
    .ap_idle(ap_idle), .ap_done(ap_done), .cfg_lock(cfg_lock),
    .ss_tvalid(ss_tvalid), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tlast(sm_tlast),
    .tap_EN(tap_EN), .tap_A(tap_A), .data_EN(data_EN), .data_WE(data_WE),
    .data_A(data_A), .data_zero(data_zero), .mac_en(mac_en), .mac_first(mac_first),
    .dbg_state(dbg_state)
  );

  // ---------------- BRAMs and MAC datapath around the controller ----------------
  logic [31:0] tap_mem [0:NT-1];
  logic [31:0] data_mem [0:NT-1] = '{default: 32'h0000_0155};
  logic [31:0] tap_do = 32'd0, data_do = 32'd0, acc = 32'd0;

  always @(posedge clk) begin
    if (tap_EN) tap_do <= (tap_A[11:2] < NT) ? tap_mem[tap_A[5:2]] : 32'hbad0_bad0;
    if (data_EN) begin
      data_do <= (data_A[11:2] < NT) ? data_mem[data_A[5:2]] : 32'hbad1_bad1;
      if (data_WE == 4'hF && data_A[11:2] < NT)
        data_mem[data_A[5:2]] <= data_zero ? 32'd0 : ss_tdata;
    end
    if (mac_en) acc <= mac_first ? tap_do * data_do : acc + tap_do * data_do;
  end

  // ---------------- scoreboard state ----------------
  int errors = 0, checks = 0;
  logic [32:0] exp_q[$];
  logic [31:0] h [0:NT-1];
  logic [31:0] xs[$];
  int run_n = 1, run_len = 1, smp = 0, gap_max = 0, rdy_mode = 0;
  bit per_en = 0, have_prev = 0;
  int prev_cyc = 0, first_hs_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- sm_tready driver ----------------
  initial begin
    sm_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        0: sm_tready = 1'b1;
        1: sm_tready = ($urandom_range(0, 3) != 0);
        default: sm_tready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [32:0] e;
    bit prev_v, prev_r;
    prev_v = 0; prev_r = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 0;
        continue;
      end
      if (prev_v && !prev_r) check("sm_tvalid_held", sm_tvalid, 1);
      if (sm_tvalid) check("ss_tready_in_out", ss_tready, 0);
      if (sm_tvalid && sm_tready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got tlast=%0d data=0x%0h, expected no output", sm_tlast, acc);
        end else begin
          e = exp_q.pop_front();
          check("sm_result", {31'd0, sm_tlast, acc}, {31'd0, e});
        end
        if (per_en) begin
          if (have_prev) check("sample_period", cyc - prev_cyc, run_n + 3);
          else           check("first_latency", cyc - first_hs_cyc, run_n + 2);
          have_prev = 1;
          prev_cyc  = cyc;
        end
      end
      prev_v = sm_tvalid;
      prev_r = sm_tready;
    end
  end

  // ---------------- driver tasks (entered just after a rising edge) ----------------
  task automatic start_run(input int n, input int len);
    for (int i = 0; i < NT; i++) begin
      h[i] = $urandom_range(0, 255);
      tap_mem[i] = h[i];
    end
    xs.delete();
    run_n = n; run_len = len; smp = 0;
    cfg_tap_num = 4'(n); cfg_data_length = len;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(negedge clk);
    check("idle_falls", ap_idle, 0);
    check("lock_rises", cfg_lock, 1);
`ifdef FIR_CTRL_ZERO_FILL_EN
    for (int i = 0; i < NT; i++) begin
      if (i > 0) @(negedge clk);
      check("clear_ctl", {data_EN, data_WE, data_zero}, {1'b1, 4'hF, 1'b1});
      check("clear_addr", data_A, 4 * i);
    end
`else
    check("direct_wait_in", ss_tready, 1);
`endif
    @(posedge clk); #1;
  endtask

  task automatic send_sample(input bit last_flag);
    logic [31:0] x, y;
    int gap, w;
    x = $urandom_range(0, 1023);
    gap = $urandom_range(0, gap_max);
    repeat (gap) begin @(posedge clk); #1; end
    ss_tvalid = 1'b1; ss_tdata = x; ss_tlast = last_flag;
    w = 0;
    forever begin
      @(negedge clk);
      if (ss_tready) break;
      w++;
      if (w > 300) break;
    end
    if (w > 300) begin
      checks++; errors++;
      $display("FAIL ss_handshake_timeout: got no ss_tready in 300 cycles, expected ss_tready=1");
    end else begin
      check("wr_addr", data_A, 4 * (smp % NT));
      check("wr_we", data_WE, 4'hF);
      if (smp == 0) first_hs_cyc = cyc;
      xs.push_back(x);
      y = 32'd0;
      for (int j = 0; j < run_n && j <= smp; j++) y += h[j] * xs[smp - j];
      exp_q.push_back({last_flag || (smp == run_len - 1), y});
      smp++;
    end
    @(posedge clk); #1;
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!ap_done && w < 2000) begin @(negedge clk); w++; end
    check("done_set", ap_done, 1);
    check("idle_after_run", ap_idle, 1);
    check("outputs_drained", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  task automatic try_bad_start(input int n, input int len);
    cfg_tap_num = 4'(n); cfg_data_length = len;
    ap_start = 1'b1;
    @(posedge clk); #1;
    ap_start = 1'b0;
    @(negedge clk);
    check("bad_start_idle", ap_idle, 1);
    check("bad_start_lock", cfg_lock, 0);
    check("bad_start_keeps_done", ap_done, 1);
    @(posedge clk); #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by %0t, expected the bench to finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", ap_idle, 1);
    check("rst_state", dbg_state, 0);
    check("rst_outputs", {ap_done, cfg_lock, ss_tready, sm_tvalid, sm_tlast, tap_EN, tap_A,
                          data_EN, data_WE, data_A, data_zero, mac_en, mac_first}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Run A: 11 taps, length 600, early tlast on sample 13, back-to-back
    // input and sm_tready=1: checks latency, 14-cycle period, pointer wrap.
    rdy_mode = 0; gap_max = 0;
    start_run(11, 600);
    per_en = 1; have_prev = 0;
    for (int i = 0; i < 14; i++) send_sample(i == 13);
    wait_done();
    per_en = 0;

    // Starts that must be ignored: zero taps, too many taps, zero length.
    try_bad_start(0, 5);
    try_bad_start(12, 5);
    try_bad_start(3, 0);

    // Run B: random taps and length, input gaps, random backpressure,
    // and a stray ap_start in the middle of the run.
    rdy_mode = 1; gap_max = 2;
    begin
      int n, len;
      n = $urandom_range(1, 11);
      len = $urandom_range(8, 20);
      start_run(n, len);
      for (int i = 0; i < len; i++) begin
        send_sample(1'b0);
        if (i == 2) begin
          ap_start = 1'b1;
          @(posedge clk); #1;
          ap_start = 1'b0;
          @(negedge clk);
          check("midrun_start_ignored", ap_idle, 0);
          @(posedge clk); #1;
        end
      end
    end
    wait_done();

    // Run C: 5 taps, output held off 5 cycles, tlast on the 9th sample.
    gap_max = 0;
    start_run(5, 600);
    rdy_mode = 2;
    send_sample(1'b0);
    begin
      int w;
      w = 0;
      while (!sm_tvalid && w < 40) begin @(negedge clk); w++; end
      check("stall_valid_seen", sm_tvalid, 1);
      repeat (5) begin
        @(negedge clk);
        check("stall_valid_held", sm_tvalid, 1);
        check("stall_ss_blocked", ss_tready, 0);
      end
    end
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int i = 1; i < 9; i++) send_sample(i == 8);
    wait_done();
    ap_done_clr = 1'b1;
    @(posedge clk); #1;
    ap_done_clr = 1'b0;
    @(negedge clk);
    check("done_cleared", ap_done, 0);
    check("idle_after_clr", ap_idle, 1);
    @(posedge clk); #1;

    // Reset during MAC aborts the run with no ap_done.
    rdy_mode = 0;
    start_run(11, 10);
    send_sample(1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_idle", ap_idle, 1);
    check("midrst_outputs", {ap_done, cfg_lock, ss_tready, sm_tvalid, sm_tlast, tap_EN, tap_A,
                             data_EN, data_WE, data_A, data_zero, mac_en, mac_first}, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_no_done", ap_done, 0);
    @(posedge clk); #1;

    // Run D: single tap, ends by length count.
    start_run(1, 3);
    for (int i = 0; i < 3; i++) send_sample(1'b0);
    wait_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
